// File: rtl/shift_engine.sv
// Multi-cycle barrel-lite shifter: shifts up to STEP bits per cycle until the latched amount is consumed.
// Define SHIFT_ENGINE_ROTATE_EN to build rotate-right for op 11; otherwise op 11 acts as SRL.
module shift_engine #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res
);
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam logic [SHAMT_W-1:0] STEP_K = SHAMT_W'(STEP);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   work;
    logic [1:0]         mode;
    logic [SHAMT_W-1:0] rem;
    logic [SHAMT_W-1:0] k;
    logic [SHAMT_W-1:0] amt;
    logic [WIDTH-1:0]   shifted;
    logic               accept;

    assign amt    = rs[SHAMT_W-1:0];
    assign accept = start && (state != SHIFT);
    assign k      = (rem < STEP_K) ? rem : STEP_K;

`ifdef SHIFT_ENGINE_ROTATE_EN
    localparam logic [SHAMT_W:0] WIDTH_SH = (SHAMT_W+1)'(WIDTH);
    logic [SHAMT_W:0] wrap_amt;
    assign wrap_amt = WIDTH_SH - {1'b0, k};
`endif

    always_comb begin
        shifted = work >> k;
        case (mode)
            2'b00: shifted = work << k;
            2'b10: shifted = WIDTH'($signed(work) >>> k);
`ifdef SHIFT_ENGINE_ROTATE_EN
            2'b11: shifted = (work >> k) | (work << wrap_amt);
`endif
            default: shifted = work >> k;
        endcase
    end

    // Outputs are flops set alongside the state so busy/done are glitch-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            work  <= '0;
            mode  <= '0;
            rem   <= '0;
            res   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (state == SHIFT) begin
            work <= shifted;
            rem  <= rem - k;
            if (rem == k) begin
                state <= DONE;
                done  <= 1'b1;
                res   <= shifted;
            end
        end else if (accept) begin
            work <= rt;
            mode <= op;
            rem  <= amt;
            busy <= 1'b1;
            if (amt == '0) begin
                state <= DONE;
                done  <= 1'b1;
                res   <= rt;
            end else begin
                state <= SHIFT;
                done  <= 1'b0;
            end
        end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_shift_engine.sv
// Self-checking bench for shift_engine (WIDTH=32, STEP=4): vector table plus hand-built corner sequences.
module tb_shift_engine;
    localparam int WIDTH = 32;
    localparam int STEP  = 4;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [31:0] rs    = '0;
    logic [31:0] rt    = '0;
    logic        busy;
    logic        done;
    logic [31:0] res;

    shift_engine #(.WIDTH(WIDTH), .STEP(STEP)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs(rs), .rt(rt), .busy(busy), .done(done), .res(res)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] res;
    } vec_t;
    vec_t vecs[11];

    logic [31:0] last_res = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] r, input logic [31:0] amt);
        exp_t e;
        e.res = r;
        e.lat = (int'(amt[4:0]) + STEP - 1) / STEP;
        sb.push_back(e);
    endtask

    // Called at the negedge following acceptance (lat0 = cycles already elapsed since then).
    task automatic wait_done(input string name, input int lat0);
        int   lat;
        exp_t e;
        lat = lat0;
        while (!done && lat < 20) begin
            check({name, "_busy"}, {31'd0, busy}, 32'd1);
            check({name, "_hold"}, res, last_res);
            @(negedge clk);
            lat++;
        end
        if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL %s_sb: got empty scoreboard want entry", name);
        end else begin
            e = sb.pop_front();
            if (!done) begin
                total++; bad++;
                $display("FAIL %s_timeout: got no done want done", name);
            end else begin
                check({name, "_res"}, res, e.res);
                check({name, "_lat"}, lat, e.lat);
                check({name, "_busy_done"}, {31'd0, busy}, 32'd1);
                last_res = e.res;
            end
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] r);
        start = 1'b1; op = o; rs = a; rt = d;
        push(r, a);
        @(negedge clk);
        start = 1'b0;
        op = 2'($urandom);
        rs = $urandom;
        rt = $urandom;
    endtask

    initial begin
        vecs[0]  = '{2'b00, 32'd31,       32'h00000001, 32'h80000000};
        vecs[1]  = '{2'b10, 32'd4,        32'h80000000, 32'hF8000000};
        vecs[2]  = '{2'b01, 32'd4,        32'h80000000, 32'h08000000};
`ifdef SHIFT_ENGINE_ROTATE_EN
        vecs[3]  = '{2'b11, 32'd8,        32'h12345678, 32'h78123456};
        vecs[10] = '{2'b11, 32'd1,        32'h00000001, 32'h80000000};
`else
        vecs[3]  = '{2'b11, 32'd8,        32'h12345678, 32'h00123456};
        vecs[10] = '{2'b11, 32'd1,        32'h00000001, 32'h00000000};
`endif
        vecs[4]  = '{2'b01, 32'h00000020, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[5]  = '{2'b10, 32'd5,        32'h80000001, 32'hFC000000};
        vecs[6]  = '{2'b00, 32'hFFFFFFE3, 32'hA5A5A5A5, 32'h2D2D2D28};
        vecs[7]  = '{2'b10, 32'd31,       32'h7FFFFFFF, 32'h00000000};
        vecs[8]  = '{2'b01, 32'd1,        32'hFFFFFFFF, 32'h7FFFFFFF};
        vecs[9]  = '{2'b10, 32'd7,        32'hF0000000, 32'hFFE00000};

        // Reset state
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_res", res, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Table vectors; the first is accepted on the first edge after reset release
        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].res);
            wait_done($sformatf("vec%0d", i), 0);
            @(negedge clk);
            check($sformatf("vec%0d_idle_done", i), {31'd0, done}, 32'd0);
            check($sformatf("vec%0d_idle_busy", i), {31'd0, busy}, 32'd0);
            check($sformatf("vec%0d_idle_res", i), res, last_res);
        end

        // Zero shift followed by back-to-back start held in DONE
        start = 1'b1; op = 2'b01; rs = 32'h00000020; rt = 32'hDEADBEEF;
        push(32'hDEADBEEF, 32'h20);
        @(negedge clk);
        wait_done("b2b_first", 0);
        op = 2'b00; rs = 32'd1;
        push(32'hBD5B7DDE, 32'd1);
        @(negedge clk);
        start = 1'b0; rt = '0;
        check("b2b_done_low", {31'd0, done}, 32'd0);
        wait_done("b2b_second", 0);
        @(negedge clk);

        // Start during SHIFT must be ignored
        start = 1'b1; op = 2'b01; rs = 32'd20; rt = 32'hFFFF0000;
        push(32'h00000FFF, 32'd20);
        @(negedge clk);
        op = 2'b00; rs = 32'd3; rt = 32'h00000001;
        for (int c = 0; c < 3; c++) begin
            check("ign_done", {31'd0, done}, 32'd0);
            check("ign_busy", {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        start = 1'b0;
        wait_done("ign", 3);
        @(negedge clk);

        // Reset mid-SHIFT abandons the operation
        start = 1'b1; op = 2'b01; rs = 32'd20; rt = 32'hFFFF0000;
        @(negedge clk);
        start = 1'b0;
        check("mid_busy_pre", {31'd0, busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_res", res, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("post_rst_done", {31'd0, done}, 32'd0);
        end
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/shift_engine.md
SHIFT_ENGINE -- requirements
Module: shift_engine

Interface
- REQ-001 Parameter WIDTH, default 32: datapath width; power of two, 8..64.
- REQ-002 Parameter STEP, default 4: maximum bit positions shifted per cycle; 1..WIDTH/2.
- REQ-003 Localparam SHAMT_W = clog2(WIDTH): shift-amount width.
- REQ-004 clk  input  1: single clock; all state updates on rising edge.
- REQ-005 reset  input  1: asynchronous, active-low reset.
- REQ-006 start  input  1: request; sampled only when the engine can accept (see REQ-011).
- REQ-007 op  input  2: 00 SLL, 01 SRL, 10 SRA, 11 ROR (see Configuration).
- REQ-008 rs  input  WIDTH: shift amount; only rs[SHAMT_W-1:0] used, upper bits ignored.
- REQ-009 rt  input  WIDTH: operand to shift.
- REQ-010 busy  output  1 / done  output  1 / res  output  WIDTH: status, one-cycle completion pulse, registered result.

Function
- REQ-011 States IDLE, SHIFT, DONE; start accepted only in IDLE or DONE; start in SHIFT ignored, with no effect on operands or progress.
- REQ-012 On acceptance: latch rt into the work register, op into the mode register, and rs[SHAMT_W-1:0] into the remaining-count register rem.
- REQ-013 Acceptance with rem=0: next state DONE; with rem>0: next state SHIFT.
- REQ-014 In SHIFT, each edge shifts the work register by k=min(rem,STEP) in the latched mode; rem decrements by k; on reaching 0, next state is DONE.
- REQ-015 Latency: start sampled at edge E; done high in the cycle after edge E+N, where N=ceil(shamt/STEP) (N=0 for shamt 0).
- REQ-016 SLL/SRL fill with 0; SRA fills with bit WIDTH-1 of the latched operand; ROR wraps bits shifted out of bit 0 into bit WIDTH-1.
- REQ-017 busy = (state != IDLE); done = (state == DONE) for exactly one cycle, then IDLE unless start is accepted (back-to-back).
- REQ-018 res updates only on entering DONE and then holds its value until the next entry into DONE; res never shows intermediate shift values.
- REQ-019 Operand inputs may change freely after acceptance; the result depends only on latched values.

Reset
- REQ-020 reset low forces, asynchronously: state IDLE, busy 0, done 0, res 0, and the work, mode and rem registers all 0.
- REQ-021 Reset during SHIFT or DONE abandons the operation; no done pulse follows the release of reset.
- REQ-022 First acceptance is possible at the first rising edge after reset deasserts.

Configuration
- REQ-023 Macro SHIFT_ENGINE_ROTATE_EN defined: op 11 performs ROR per REQ-016.
- REQ-024 Macro SHIFT_ENGINE_ROTATE_EN undefined: no rotate logic is built; op 11 behaves exactly as SRL (op 01).

Verification (WIDTH=32, STEP=4)
- REQ-025 SLL, rt=0x00000001, rs=31 -> res=0x80000000; done in the cycle after edge E+8; busy high throughout.
- REQ-026 SRA, rt=0x80000000, rs=4 -> res=0xF8000000 after N=1; SRL with the same inputs -> 0x08000000.
- REQ-027 op=11, rt=0x12345678, rs=8 -> 0x78123456 with the macro defined; 0x00123456 without it.
- REQ-028 SRL, rt=0xDEADBEEF, rs=0x00000020 (low 5 bits = 0) -> res=0xDEADBEEF, done in the cycle after edge E; then start held in DONE with SLL, rs=1 -> 0xBD5B7DDE.
- REQ-029 start with rt=0xFFFF0000, rs=20, plus a second start during SHIFT -> second start ignored; then reset pulsed low mid-SHIFT -> busy, done and res equal 0 immediately, and no done pulse follows.
